// File: rtl/apb_multi_slave_regbank.sv
// apb_multi_slave_regbank: APB completer with NUM_SLAVES register banks, wait states, byte strobes and error response
module apb_multi_slave_regbank #(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int PROT_CHECK  = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NUM_SLAVES-1:0]   psel,
  input  logic                    penable,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW = $clog2(DEPTH);
  localparam int BW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [3:0] CNT0 = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BW-1:0] bank_q, bank_d, sel_bank;
  logic [IW-1:0] idx_q, idx_d;
  logic wr_q, wr_d, err_q, err_d, req_err, setup;
  logic [SW-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, prdata_q, prdata_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_SLAVES][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [NUM_SLAVES][DEPTH];
  logic unused_prot;
  assign unused_prot = ^pprot[2:1];
  assign prdata = prdata_q;
  assign pready = pready_q;
  assign pslverr = pslverr_q;
  // decode a new request: lowest selected bank plus every error condition
  always_comb begin
    sel_bank = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) if (psel[i]) sel_bank = BW'(i);
    setup = |psel && !penable;
    req_err = |(psel & (psel - NUM_SLAVES'(1))) || |(paddr & ADDR_WIDTH'(SW - 1)) ||
              (paddr >> LSB) >= ADDR_WIDTH'(DEPTH) || (PROT_CHECK != 0 && pwrite && !pprot[0]);
  end
  // state register, latched request and storage
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bank_q <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      strb_q <= '0;
      wdata_q <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bank_q <= bank_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      err_q <= err_d;
      strb_q <= strb_d;
      wdata_q <= wdata_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      mem_q <= mem_d;
    end
  end
  // next state: capture request in setup, count wait states, abort when psel drops
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bank_d = bank_q;
    idx_d = idx_q;
    wr_d = wr_q;
    err_d = err_q;
    strb_d = strb_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && setup) begin
      state_d = WAIT_STATES == 0 ? RESP : WAIT;
      cnt_d = CNT0;
      bank_d = sel_bank;
      idx_d = paddr[LSB +: IW];
      wr_d = pwrite;
      err_d = req_err;
      strb_d = pstrb;
      wdata_d = pwdata;
    end else if (state_q == WAIT) begin
      state_d = !(|psel) ? IDLE : cnt_q == '0 ? RESP : WAIT;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  // outputs registered on RESP entry; write commits on the edge leaving RESP
  always_comb begin
    pready_d = state_d == RESP;
    pslverr_d = state_d == RESP && err_d;
    prdata_d = (state_d == RESP && !wr_d && !err_d) ? mem_q[bank_d][idx_d] : '0;
    mem_d = mem_q;
    for (int b = 0; b < SW; b++)
      if (state_q == RESP && wr_q && !err_q && strb_q[b]) mem_d[bank_q][idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
  end
endmodule
